// File: rtl/piso.sv
// piso: parallel-in serial-out serializer with a one-word hold buffer for gapless streaming
// Ports:
//    sclk_i   clock, all state updates on its rising edge
//    rst_i    synchronous active-high reset
//    data_i   parallel word, taken when valid_i && ready_o
//    valid_i  data_i holds a valid word
//    ready_o  a word can be accepted this cycle
//    data_o   current serial bit
//    valid_o  data_o holds a valid bit
//    ready_i  sink takes data_o this cycle
module piso #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              sclk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              data_o,
   output logic              valid_o,
   input  logic              ready_i
);
   localparam int CW = $clog2(DATA_W);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d;
   logic [CW-1:0]     count_q, count_d;
   logic              hold_valid_q, hold_valid_d;
   logic              accept, xfer, last;
   assign ready_o = !rst_i && !hold_valid_q;
   assign valid_o = state_q == SHIFT;
   // the outgoing bit always sits at the transmit end of the shift register
   assign data_o  = valid_o && (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
   assign accept  = valid_i && ready_o;
   assign xfer    = valid_o && ready_i;
   assign last    = count_q == CW'(DATA_W-1);
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      count_d      = count_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (state_q == IDLE) begin
         if (accept) begin
            shift_d = data_i;
            count_d = '0;
            state_d = SHIFT;
         end
      end else if (xfer && last) begin
         // refill from hold first, else straight from the input, else go idle
         count_d = '0;
         if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
         end else if (accept) begin
            shift_d = data_i;
         end else begin
            state_d = IDLE;
         end
      end else begin
         if (xfer) begin
            shift_d = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
            count_d = count_q + CW'(1);
         end
         if (accept) begin
            hold_d       = data_i;
            hold_valid_d = 1'b1;
         end
      end
   end
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         count_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         count_q      <= count_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end
endmodule

// File: tb/tb_piso.sv
// tb_piso: scoreboard bench for piso, MSB-first and LSB-first instances driven in parallel
module tb_piso;
   logic       sclk_i = 1'b0;
   logic       rst_i, valid_i, ready_i;
   logic [7:0] data_i;
   logic       rm, dm, vm, rl, dl, vl;
   logic       q[$], p[$];
   int         n = 0, fails = 0;
   always #5 sclk_i = ~sclk_i;
   piso #(.DATA_W(8), .MSB_FIRST(1'b1)) u_m (
      .sclk_i(sclk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(rm), .data_o(dm), .valid_o(vm), .ready_i(ready_i));
   piso #(.DATA_W(8), .MSB_FIRST(1'b0)) u_l (
      .sclk_i(sclk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(rl), .data_o(dl), .valid_o(vl), .ready_i(ready_i));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge sclk_i);
      #1;
   endtask
   // q holds expected MSB-first bits, p expected LSB-first bits
   always @(negedge sclk_i) begin
      if (!rst_i) begin
         if (vm && ready_i) begin
            chk("m_exp_avail", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("m_bit", 32'(dm), 32'(q.pop_front()));
         end
         if (vl && ready_i) begin
            chk("l_exp_avail", 32'(p.size() != 0), 1);
            if (p.size() != 0) chk("l_bit", 32'(dl), 32'(p.pop_front()));
         end
         if (valid_i && rm)
            for (int i = 0; i < 8; i++) begin
               q.push_back(data_i[7-i]);
               p.push_back(data_i[i]);
            end
      end
   end
   task automatic run_word(input logic [7:0] w);
      valid_i = 1'b1;
      data_i  = w;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sclk_i);
         chk("stream_valid_m", 32'(vm), 1);
         chk("stream_valid_l", 32'(vl), 1);
         tick();
      end
      @(negedge sclk_i);
      chk("end_valid", 32'(vm | vl), 0);
      chk("end_data", 32'(dm | dl), 0);
      chk("end_count", 32'(u_m.count_q | u_l.count_q), 0);
      chk("end_queue", 32'(q.size() + p.size()), 0);
      tick();
   endtask
   initial begin
      logic       prev, d5;
      logic [2:0] c5;
      int         k;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
      tick();
      tick();
      @(negedge sclk_i);
      chk("rst_valid", 32'(vm | vl), 0);
      chk("rst_data", 32'(dm | dl), 0);
      chk("rst_ready", 32'(rm | rl), 0);
      chk("rst_count", 32'(u_m.count_q | u_l.count_q), 0);
      tick();
      rst_i = 1'b0;
      @(negedge sclk_i);
      chk("post_rst_ready", 32'(rm & rl), 1);
      tick();
      ready_i = 1'b1;
      run_word(8'hA5);
      run_word(8'h01);
      ready_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'hF0;
      tick();
      valid_i = 1'b0;
      prev = 1'b0; d5 = 1'b0; c5 = '0;
      for (k = 1; k <= 14; k++) begin
         @(negedge sclk_i);
         if (k == 1) begin
            chk("bp_stall_valid", 32'(vm), 1);
            chk("bp_first_count", 32'(u_m.count_q), 0);
         end
         if (k == 5) begin d5 = dm; c5 = u_m.count_q; end
         if (k == 6) begin
            chk("bp_hold_data", 32'(dm), 32'(d5));
            chk("bp_hold_count", 32'(u_m.count_q), 32'(c5));
         end
         prev = vm;
         tick();
         ready_i = (k == 4 || k == 5) ? 1'b0 : prev;
      end
      @(negedge sclk_i);
      chk("bp_done_valid", 32'(vm), 0);
      chk("bp_done_queue", 32'(q.size() + p.size()), 0);
      tick();
      ready_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'hA5;
      tick();
      data_i = 8'h3C;
      for (k = 1; k <= 18; k++) begin
         @(negedge sclk_i);
         chk("str_valid", 32'(vm), 32'(k <= 16));
         chk("str_ready", 32'(rm), 32'(k < 2 || k > 8));
         tick();
         if (k == 1) valid_i = 1'b0;
      end
      chk("str_queue", 32'(q.size() + p.size()), 0);
      valid_i = 1'b1;
      data_i  = 8'hFF;
      tick();
      data_i = 8'h55;
      tick();
      valid_i = 1'b0;
      tick();
      tick();
      tick();
      rst_i = 1'b1;
      q.delete();
      p.delete();
      tick();
      rst_i = 1'b0;
      @(negedge sclk_i);
      chk("mid_rst_valid", 32'(vm | vl), 0);
      chk("mid_rst_data", 32'(dm | dl), 0);
      chk("mid_rst_hold", 32'(u_m.hold_valid_q | u_l.hold_valid_q), 0);
      chk("mid_rst_count", 32'(u_m.count_q | u_l.count_q), 0);
      chk("mid_rst_ready", 32'(rm), 1);
      tick();
      run_word(8'h81);
      k = 0;
      while (vm && k < 64) begin
         tick();
         k++;
      end
      chk("final_idle", 32'(vm), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the parallel word width in bits (minimum 2).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1; 1 serializes bit DATA_W-1 first, 0 serializes bit 0 first.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset, with all state updated on the rising edge of sclk_i.
REQ-004 sclk_i  input  1  sole clock; all registers update on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 data_i  input  DATA_W  parallel word to serialize.
REQ-007 valid_i  input  1  data_i holds a valid word.
REQ-008 ready_o  output  1  block can accept a word this cycle.
REQ-009 data_o  output  1  current serial bit.
REQ-010 valid_o  output  1  data_o holds a valid bit.
REQ-011 ready_i  input  1  sink accepts data_o this cycle.

Function
REQ-012 The design SHALL hold internal registers: shift register (DATA_W), bit counter named count (clog2(DATA_W) bits), state (IDLE/SHIFT) and a one-word hold buffer with flag hold_valid.
REQ-013 A word SHALL be accepted on a rising edge where valid_i=1 and ready_o=1; with valid_i=0 or ready_o=0, data_i SHALL be ignored.
REQ-014 ready_o SHALL be 1 when rst_i=0 and hold_valid=0, and 0 otherwise (combinational from registers).
REQ-015 In IDLE, an accepted word SHALL load the shift register, set count=0 and enter SHIFT on that edge; the first bit SHALL appear on data_o with valid_o=1 in the next cycle (1-cycle latency).
REQ-016 In SHIFT, an accepted word SHALL be stored in the hold buffer with hold_valid=1.
REQ-017 valid_o SHALL be 1 exactly while in SHIFT; data_o SHALL be the bit at index count in transmit order (MSB_FIRST-selected), and 0 in IDLE.
REQ-018 A bit transfer SHALL occur on an edge where valid_o=1 and ready_i=1; count then increments by 1.
REQ-019 With valid_o=1 and ready_i=0, data_o, count and the shift register SHALL hold unchanged indefinitely.
REQ-020 On transfer of the last bit (count=DATA_W-1): if hold_valid=1, the hold word SHALL load into the shift register, hold_valid clears, count=0, state stays SHIFT; else, if a word is accepted on that same edge, it SHALL load directly, count=0, state stays SHIFT; else state returns to IDLE with count=0.
REQ-021 Back-to-back words with ready_i held high SHALL stream with no idle cycle between the last bit of one word and the first bit of the next.
REQ-022 count SHALL never exceed DATA_W-1 and SHALL read 0 in IDLE.

Reset
REQ-023 While rst_i=1 at a rising edge: state=IDLE, count=0, shift register=0, hold buffer=0, hold_valid=0.
REQ-024 During and after reset until a word is accepted: valid_o=0, data_o=0; ready_o=0 while rst_i=1 and 1 from the first cycle after rst_i falls.
REQ-025 Reset asserted mid-word SHALL discard the in-flight and held words with no further serial output; the first word accepted after reset SHALL start at count=0.

Verification
REQ-026 Reset: rst_i=1 for 2 cycles -> valid_o=0, data_o=0, ready_o=0, count=0; cycle after release ready_o=1.
REQ-027 MSB_FIRST=1, accept 8'hA5, ready_i=1 -> data_o 1,0,1,0,0,1,0,1 on 8 consecutive cycles with valid_o=1, then valid_o=0, count=0.
REQ-028 MSB_FIRST=0, accept 8'hA5 -> data_o 1,0,1,0,0,1,0,1 (bit 0 first); accept 8'h01 -> 1,0,0,0,0,0,0,0.
REQ-029 Backpressure: accept 8'hF0, ready_i follows valid_o one cycle late (0 on bit 0, then 1) -> each bit held until handshake, all 8 bits 1,1,1,1,0,0,0,0 delivered in order, none dropped.
REQ-030 Streaming: valid_i=1 with 8'hA5 then 8'h3C, ready_i=1 -> 16 contiguous valid bits A5 then 3C; ready_o=0 while hold full, 1 after hold drains.
REQ-031 Reset mid-word: rst_i=1 after bit 3 of 8'hFF -> valid_o=0 next cycle, hold cleared; subsequent 8'h81 serializes fully from count=0.
